// File: rtl/io_uart_tx.sv
// io_uart_tx -- memory-mapped 8N1 UART transmitter on the CPU IO bus.
//
// CPU stores to BASE_ADDR queue a byte into a small TX FIFO. A shift engine
// drains the FIFO and sends each byte as start bit, eight data bits (LSB
// first) and a stop bit. Back-to-back bytes are sent with no idle gap. A
// status register at BASE_ADDR+1 is read combinationally so software can
// poll for space. A store of any value to the status address clears the
// sticky overflow flag.
//
// Ports
//   clock       in   1      system clock, all state on posedge
//   reset       in   1      synchronous, active-high
//   io_addr     in   WIDTH  IO address from the CPU
//   io_write    in   1      one-cycle write strobe
//   io_wr_data  in   WIDTH  write data, only [7:0] used by the data register
//   io_rd_data  out  WIDTH  status at BASE_ADDR+1, zero for any other address
//   uart_tx     out  1      serial output, idle high, driven from a flop
//
// Status word: [12:8] count, [2] overflow, [1] full, [0] busy.
module io_uart_tx #(
  parameter int              WIDTH        = 16,
  parameter logic [WIDTH-1:0] BASE_ADDR   = 16'hC000,
  parameter int              CLKS_PER_BIT = 217,
  parameter int              FIFO_LOG2    = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] io_addr,
  input  logic             io_write,
  input  logic [WIDTH-1:0] io_wr_data,
  output logic [WIDTH-1:0] io_rd_data,
  output logic             uart_tx
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_LOG2:0] CNT_FULL  = {1'b1, {FIFO_LOG2{1'b0}}};
  localparam logic [WIDTH-1:0]   STAT_ADDR = BASE_ADDR + WIDTH'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  // FIFO storage and control
  logic [7:0]           r_mem [DEPTH];
  logic [FIFO_LOG2-1:0] r_wr_ptr;
  logic [FIFO_LOG2-1:0] r_rd_ptr;
  logic [FIFO_LOG2:0]   r_count;
  logic                 r_ovf;

  // Shift engine
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [CNT_W-1:0] w_clk_cnt_nxt;
  logic [2:0]       r_bit_idx;
  logic [2:0]       w_bit_idx_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic             r_tx;
  logic             w_tx_nxt;

  logic       w_wr_data;
  logic       w_wr_stat;
  logic       w_full;
  logic       w_empty;
  logic       w_pop;
  logic       w_push;
  logic       w_drop;
  logic       w_last;
  logic       w_busy;
  logic [7:0] w_head;
  logic [4:0] w_cnt5;
  logic [15:0] w_stat;

  assign w_wr_data = io_write && (io_addr == BASE_ADDR);
  assign w_wr_stat = io_write && (io_addr == STAT_ADDR);
  assign w_full    = (r_count == CNT_FULL);
  assign w_empty   = (r_count == '0);
  assign w_head    = r_mem[r_rd_ptr];
  assign w_last    = (r_clk_cnt == CNT_LAST);
  assign w_busy    = (r_state != S_IDLE);

  // A full FIFO still accepts a byte when the engine pops in the same
  // cycle, since a slot frees up at that edge.
  assign w_push = w_wr_data && (!w_full || w_pop);
  assign w_drop = w_wr_data && !w_push;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      // Setting overflow takes priority over a clear in the same cycle.
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_wr_stat) r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= io_wr_data[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_clk_cnt <= w_clk_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_tx      <= w_tx_nxt;
    end
  end

  always_ff @(posedge clock) begin
    r_shift <= w_shift_nxt;
  end

  // w_tx_nxt is the line level for the cycle after the edge, so every
  // transition sets the level of the bit it enters.
  always_comb begin
    w_state_nxt   = r_state;
    w_clk_cnt_nxt = r_clk_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_tx_nxt      = r_tx;
    w_pop         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_nxt = 1'b1;
        if (!w_empty) begin
          w_pop         = 1'b1;
          w_shift_nxt   = w_head;
          w_clk_cnt_nxt = '0;
          w_state_nxt   = S_START;
          w_tx_nxt      = 1'b0;
        end
      end
      S_START: begin
        if (w_last) begin
          w_clk_cnt_nxt = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = S_DATA;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (w_last) begin
          w_clk_cnt_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
            w_tx_nxt    = 1'b1;
          end else begin
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_bit_idx_nxt = r_bit_idx + 1'b1;
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (w_last) begin
          w_clk_cnt_nxt = '0;
          if (!w_empty) begin
            // Chain straight into the next start bit, no idle gap.
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_state_nxt = S_START;
            w_tx_nxt    = 1'b0;
          end else begin
            w_state_nxt = S_IDLE;
            w_tx_nxt    = 1'b1;
          end
        end else begin
          w_clk_cnt_nxt = r_clk_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_tx_nxt    = 1'b1;
      end
    endcase
  end

  assign w_cnt5     = 5'(r_count);
  assign w_stat     = {3'b000, w_cnt5, 5'b00000, r_ovf, w_full, w_busy};
  assign io_rd_data = (io_addr == STAT_ADDR) ? WIDTH'(w_stat) : '0;
  assign uart_tx    = r_tx;

endmodule

// File: tb/tb_io_uart_tx.sv
// Directed bench for io_uart_tx with a 4-clock bit time and a 4-entry FIFO.
// Accepted bytes go into a scoreboard queue; a serial monitor captures each
// 40-sample frame and compares it against the expected byte's waveform.
module tb_io_uart_tx;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_write = 1'b0;
  logic [15:0] io_addr = 16'h0000;
  logic [15:0] io_wr_data = 16'h0000;
  logic [15:0] io_rd_data;
  logic        uart_tx;

  io_uart_tx #(
    .WIDTH(16),
    .BASE_ADDR(16'hC000),
    .CLKS_PER_BIT(4),
    .FIFO_LOG2(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io_addr(io_addr),
    .io_write(io_write),
    .io_wr_data(io_wr_data),
    .io_rd_data(io_rd_data),
    .uart_tx(uart_tx)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  sb[$];
  int          fall_times[$];
  int          n_start = 0;
  int          n_done  = 0;
  bit          in_frame = 1'b0;
  int          t = 0;
  logic [39:0] obs;
  logic [7:0]  mon_b;

  task automatic check(input string tag, input logic [63:0] o, input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [39:0] frame_of(input logic [7:0] b);
    logic [9:0]  bits;
    logic [39:0] f;
    bits = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++)
        f[4*k+j] = bits[k];
    return f;
  endfunction

  // Serial monitor: sampled on the falling edge, one sample per clock.
  always @(negedge clock) begin
    if (reset) begin
      in_frame = 1'b0;
    end else if (!in_frame) begin
      if (uart_tx === 1'b0) begin
        in_frame = 1'b1;
        obs = '0;
        obs[0] = uart_tx;
        t = 1;
        fall_times.push_back(cyc);
        n_start++;
      end
    end else begin
      obs[t] = uart_tx;
      t++;
      if (t == 40) begin
        in_frame = 1'b0;
        n_done++;
        check("frame_expected", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          mon_b = sb.pop_front();
          check("frame_bits", obs, frame_of(mon_b));
        end
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    io_addr = a;
    io_wr_data = d;
    io_write = 1'b1;
    @(posedge clock);
    #1;
    io_write = 1'b0;
    io_addr = 16'h0000;
    io_wr_data = 16'h0000;
  endtask

  task automatic rd(input logic [15:0] a, output logic [15:0] d);
    io_addr = a;
    #1;
    d = io_rd_data;
    io_addr = 16'h0000;
  endtask

  task automatic chk_stat(input string tag, input logic [15:0] e);
    logic [15:0] v;
    rd(16'hC001, v);
    check(tag, v, e);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 3000 && n_done < n; i++) step(1);
    check("frames_done", n_done, n);
  endtask

  task automatic wait_start(input int n);
    for (int i = 0; i < 3000 && n_start < n; i++) begin
      @(negedge clock);
      #1;
    end
    check("frames_started", n_start, n);
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step(1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  int          bs;
  int          bd;
  int          f0;
  int          wcyc;
  logic [15:0] v;

  initial begin
    // Reset state
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    check("rst_tx", uart_tx, 1);
    chk_stat("rst_stat", 16'h0000);

    // 1: single byte, latency and waveform
    wr(16'hC000, 16'h0055);
    sb.push_back(8'h55);
    wcyc = cyc;
    check("t1_tx_hold", uart_tx, 1);
    chk_stat("t1_stat_queued", 16'h0100);
    step(1);
    check("t1_tx_fall", uart_tx, 0);
    chk_stat("t1_busy", 16'h0001);
    wait_done(1);
    check("t1_fall_latency", fall_times[0], wcyc + 1);
    step(2);
    check("t1_tx_idle", uart_tx, 1);
    chk_stat("t1_idle", 16'h0000);

    // 2: three back-to-back bytes, contiguous frames
    bs = n_start;
    bd = n_done;
    wr(16'hC000, 16'h0041); sb.push_back(8'h41);
    wr(16'hC000, 16'h0042); sb.push_back(8'h42);
    wr(16'hC000, 16'h0043); sb.push_back(8'h43);
    chk_stat("t2_cnt2", 16'h0201);
    wait_start(bs + 2);
    chk_stat("t2_cnt1", 16'h0101);
    wait_start(bs + 3);
    chk_stat("t2_cnt0", 16'h0001);
    wait_done(bd + 3);
    check("t2_gap01", fall_times[bs+1] - fall_times[bs], 40);
    check("t2_gap12", fall_times[bs+2] - fall_times[bs+1], 40);
    step(2);

    // 3: overfill, sticky overflow and its clear
    bs = n_start;
    bd = n_done;
    for (int i = 0; i < 6; i++) begin
      wr(16'hC000, 16'h0010 + 16'(i));
      if (i < 5) sb.push_back(8'h10 + 8'(i));
    end
    chk_stat("t3_full_ovf", 16'h0407);
    wr(16'hC001, 16'hFFFF);
    chk_stat("t3_ovf_clr", 16'h0403);
    wait_done(bd + 5);
    step(3);
    chk_stat("t3_idle", 16'h0000);
    check("t3_frames", n_start, bs + 5);
    check("t3_sb_empty", sb.size(), 0);

    // 4: push on the exact pop cycle while full
    bs = n_start;
    bd = n_done;
    for (int i = 0; i < 5; i++) begin
      wr(16'hC000, 16'h0061 + 16'(i));
      sb.push_back(8'h61 + 8'(i));
    end
    wait_start(bs + 1);
    f0 = fall_times[bs];
    chk_stat("t4_full", 16'h0403);
    wait_cyc(f0 + 39);
    wr(16'hC000, 16'h0066);
    sb.push_back(8'h66);
    chk_stat("t4_pop_push", 16'h0403);
    wait_start(bs + 2);
    check("t4_contig", fall_times[bs+1] - f0, 40);
    wait_done(bd + 6);
    step(3);
    check("t4_sb_empty", sb.size(), 0);
    chk_stat("t4_idle", 16'h0000);

    // 5: reset during data bit 3 aborts the frame and the queue
    bs = n_start;
    wr(16'hC000, 16'h005A);
    wr(16'hC000, 16'h0077);
    wait_start(bs + 1);
    f0 = fall_times[bs];
    wait_cyc(f0 + 17);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("t5_tx_after_rst", uart_tx, 1);
    chk_stat("t5_stat_rst", 16'h0000);
    step(60);
    check("t5_no_frames", n_start, bs + 1);
    check("t5_tx_idle", uart_tx, 1);

    // 6: decode, write-only data register, upper data bits ignored
    bs = n_start;
    bd = n_done;
    wr(16'h0010, 16'h00AA);
    step(1);
    chk_stat("t6_other_addr_write", 16'h0000);
    wr(16'hC000, 16'hAB55);
    sb.push_back(8'h55);
    rd(16'hC000, v);
    check("t6_rd_data_reg", v, 16'h0000);
    rd(16'h0010, v);
    check("t6_rd_other", v, 16'h0000);
    wait_done(bd + 1);
    step(3);
    check("t6_frames", n_start, bs + 1);
    check("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
